pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage with local instruction memory and return-address stack; 1-cycle fetch latency.
// Backpressure: Stall holds the PC and emits a bubble, Stall_pm freezes the PC, the RAS and all outputs.
module pc_fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int INS_W = 24,
   parameter int RAS_DEPTH = 4,
   parameter logic [INS_W-1:0] NOP = {INS_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] jmp_loc,
   input  logic [1:0]        pc_mux_sel,
   input  logic              call,
   input  logic              Stall,
   input  logic              Stall_pm,
   input  logic              flush,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [INS_W-1:0]  ld_data,
   output logic [INS_W-1:0]  ins,
   output logic [ADDR_W-1:0] Current_Address,
   output logic              ins_valid,
   output logic              ras_ovf,
   output logic              ras_unf
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int SP_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = SP_W + 1;

   logic [INS_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] ras [RAS_DEPTH];
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] ret_addr;
   logic [SP_W-1:0]   ras_sp;
   logic [CNT_W-1:0]  ras_cnt;
   logic              redirect;
   logic              push;
   logic              pop;
   logic              ras_empty;
   logic              ras_full;

   always_comb begin
      redirect  = !Stall_pm && !Stall && (pc_mux_sel != 2'b00);
      push      = redirect && call && ((pc_mux_sel == 2'b01) || (pc_mux_sel == 2'b10));
      pop       = redirect && (pc_mux_sel == 2'b11);
      ras_empty = (ras_cnt == '0);
      ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
      ras_top   = ras[ras_sp - SP_W'(1)];
      ret_addr  = Current_Address + ADDR_W'(1);
   end

   always_comb begin
      target = jmp_loc;
      case (pc_mux_sel)
         2'b10:   target = Current_Address + jmp_loc;
         2'b11:   target = ras_empty ? jmp_loc : ras_top;
         default: target = jmp_loc;
      endcase
   end

   // Memory is deliberately outside the reset domain; the read in the fetch block sees pre-edge data.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Circular stack: when full, writing at ras_sp replaces the oldest entry.
   always_ff @(posedge clk) begin
      if (push) begin
         ras[ras_sp] <= ret_addr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc              <= '0;
         ins             <= NOP;
         Current_Address <= '0;
         ins_valid       <= 1'b0;
         ras_sp          <= '0;
         ras_cnt         <= '0;
         ras_ovf         <= 1'b0;
         ras_unf         <= 1'b0;
      end else if (Stall_pm) begin
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         ras_ovf <= push && ras_full;
         ras_unf <= pop && ras_empty;
         if (Stall) begin
            ins       <= NOP;
            ins_valid <= 1'b0;
         end else if (redirect) begin
            pc        <= target;
            ins       <= NOP;
            ins_valid <= 1'b0;
            if (push) begin
               ras_sp <= ras_sp + SP_W'(1);
               if (!ras_full) begin
                  ras_cnt <= ras_cnt + CNT_W'(1);
               end
            end
            if (pop && !ras_empty) begin
               ras_sp  <= ras_sp - SP_W'(1);
               ras_cnt <= ras_cnt - CNT_W'(1);
            end
         end else if (flush) begin
            pc        <= pc + ADDR_W'(1);
            ins       <= NOP;
            ins_valid <= 1'b0;
         end else begin
            ins             <= mem[pc];
            Current_Address <= pc;
            ins_valid       <= 1'b1;
            pc              <= pc + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  jmp_loc = '0;
   logic [1:0]  pc_mux_sel = '0;
   logic        call = 1'b0;
   logic        Stall = 1'b0;
   logic        Stall_pm = 1'b0;
   logic        flush = 1'b0;
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [23:0] ld_data = '0;
   logic [23:0] ins;
   logic [7:0]  Current_Address;
   logic        ins_valid;
   logic        ras_ovf;
   logic        ras_unf;

   pc_fetch_unit #(.ADDR_W(8), .INS_W(24), .RAS_DEPTH(4), .NOP(24'h000000)) dut (
      .clk(clk), .reset(reset), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel), .call(call),
      .Stall(Stall), .Stall_pm(Stall_pm), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .ins(ins), .Current_Address(Current_Address), .ins_valid(ins_valid),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] ins;
      logic [7:0]  ca;
      logic        v;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;

   // reference model state
   logic [23:0] m_mem [256];
   logic [7:0]  m_stack[$];
   logic [7:0]  m_pc;
   logic [23:0] m_ins;
   logic [7:0]  m_ca;
   logic        m_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 8'h00;
      m_ins = 24'h000000;
      m_ca = 8'h00;
      m_v = 1'b0;
      m_stack.delete();
   endtask

   task automatic step(input logic [1:0] sel, input logic [7:0] jmp, input logic cl,
                       input logic st, input logic spm, input logic fl,
                       input logic le, input logic [7:0] la, input logic [23:0] ld);
      exp_t       e;
      logic [7:0] tgt;
      @(negedge clk);
      pc_mux_sel = sel; jmp_loc = jmp; call = cl; Stall = st; Stall_pm = spm;
      flush = fl; ld_en = le; ld_addr = la; ld_data = ld;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (!spm) begin
         if (st) begin
            m_ins = 24'h0; m_v = 1'b0;
         end else if (sel != 2'b00) begin
            tgt = jmp;
            if (sel == 2'b10) tgt = m_ca + jmp;
            if (sel == 2'b11) begin
               if (m_stack.size() == 0) e.unf = 1'b1;
               else tgt = m_stack.pop_back();
            end
            if (cl && sel != 2'b11) begin
               m_stack.push_back(m_ca + 8'd1);
               if (m_stack.size() > 4) begin
                  void'(m_stack.pop_front());
                  e.ovf = 1'b1;
               end
            end
            m_pc = tgt; m_ins = 24'h0; m_v = 1'b0;
         end else if (fl) begin
            m_pc = m_pc + 8'd1; m_ins = 24'h0; m_v = 1'b0;
         end else begin
            m_ins = m_mem[m_pc]; m_ca = m_pc; m_v = 1'b1; m_pc = m_pc + 8'd1;
         end
      end
      if (le) m_mem[la] = ld;
      e.ins = m_ins; e.ca = m_ca; e.v = m_v;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_ins", 32'(ins), 32'h0);
      chk("rst_ca", 32'(Current_Address), 32'h0);
      chk("rst_valid", 32'(ins_valid), 32'h0);
      chk("rst_ovf", 32'(ras_ovf), 32'h0);
      chk("rst_unf", 32'(ras_unf), 32'h0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ins", 32'(ins), 32'(mon_e.ins));
            chk("cur_addr", 32'(Current_Address), 32'(mon_e.ca));
            chk("ins_valid", 32'(ins_valid), 32'(mon_e.v));
            chk("ras_ovf", 32'(ras_ovf), 32'(mon_e.ovf));
            chk("ras_unf", 32'(ras_unf), 32'(mon_e.unf));
         end
      end
   end

   initial begin
      logic [23:0] d;
      #2 reset = 1'b0;
      #1 chk_reset_vals();
      model_reset();
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         d = (i < 4) ? 24'((i + 1) * 24'h11) : 24'($urandom);
         ld_en = 1'b1; ld_addr = 8'(i); ld_data = d;
         m_mem[i] = d;
      end
      @(negedge clk);
      ld_en = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;

      // sequential fetch of the first four words
      repeat (4) idle();
      // absolute jump from address 2 to 8
      step(2'b01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
      idle();
      step(2'b01, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
      idle();
      // relative jump backwards from 0x10 and wrap at 0xFF
      step(2'b01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
      idle();
      step(2'b10, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
      idle();
      step(2'b01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
      idle();
      idle();
      // five calls then five returns
      for (int k = 0; k < 5; k++) begin
         step(2'b01, 8'(8'h20 + k * 8), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
         idle();
      end
      for (int k = 0; k < 5; k++) begin
         step(2'b11, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
         idle();
      end
      // stall bubble, then frozen cycle ignoring flush and redirect
      idle();
      step(2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
      step(2'b01, 8'h40, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 24'h0);
      idle();
      idle();
      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         logic [2:0] r;
         r = 3'($urandom_range(0, 7));
         step((r < 3'd4) ? 2'b00 : 2'(r - 3'd4), 8'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              8'($urandom), 24'($urandom));
      end
      // asynchronous reset in the middle of a stall
      step(2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0);
      @(posedge clk);
      #3 reset = 1'b0;
      #1 chk_reset_vals();
      model_reset();
      #199 reset = 1'b1;
      idle();
      idle();
      idle();
      repeat (4) @(posedge clk);
      #2 chk("drain", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
